// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: shared constants, FSM state types and address decode for the AXI4-Lite register slave
package axi4_lite_pkg;
  localparam int NUM_REGS = 16;
  localparam logic [31:0] ADDR_UPPER_MASK = 32'hFFFF_FFC0;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef logic [3:0] reg_idx_t;
  typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_VALID} rd_state_t;
  function automatic logic addr_ok(input logic [31:0] a);
    return (a & ADDR_UPPER_MASK) == 32'h0;
  endfunction
endpackage

// File: rtl/axi4_lite_regfile.sv
// axi4_lite_regfile: register bank with a byte-strobed write port and a combinational read port
module axi4_lite_regfile
  import axi4_lite_pkg::*;
#(
  parameter int N = NUM_REGS,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_i,
  input  reg_idx_t    widx_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  reg_idx_t    ridx_i,
  output logic [31:0] rdata_o
);
  logic [31:0] regs_q [N];
  logic [31:0] regs_d [N];
  // merge the enabled byte lanes into the addressed register
  always_comb begin
    regs_d = regs_q;
    if (we_i) for (int b = 0; b < 4; b++) if (wstrb_i[b]) regs_d[widx_i][8*b+:8] = wdata_i[8*b+:8];
  end
  // register storage with asynchronous clear to the reset value
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) for (int i = 0; i < N; i++) regs_q[i] <= RESET_VALUE;
    else regs_q <= regs_d;
  end
  assign rdata_o = regs_q[ridx_i];
endmodule

// File: rtl/axi4_lite_slave.sv
// axi4_lite_slave: AXI4-Lite slave with independent write (AW/W/B) and read (AR/R) FSMs over a register bank
module axi4_lite_slave
  import axi4_lite_pkg::*;
#(
  parameter int NUM_REGS = axi4_lite_pkg::NUM_REGS,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  wr_state_t wr_q, wr_d;
  rd_state_t rd_q, rd_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d, rdata_q, rdata_d, rf_rdata;
  logic [3:0] wstrb_q, wstrb_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic aw_hs, w_hs, ar_hs, wr_en;
  assign awready = aresetn && (wr_q == WR_IDLE || wr_q == WR_DATA);
  assign wready = aresetn && (wr_q == WR_IDLE || wr_q == WR_ADDR);
  assign arready = aresetn && rd_q == RD_IDLE;
  assign aw_hs = awvalid && awready;
  assign w_hs = wvalid && wready;
  assign ar_hs = arvalid && arready;
  assign bvalid = wr_q == WR_RESP;
  assign bresp = bresp_q;
  assign rvalid = rd_q == RD_VALID;
  assign rdata = rdata_q;
  assign rresp = rresp_q;
  // write FSM: latch AW and W independently; the _d copies are the effective payload used for the update
  always_comb begin
    wr_d = wr_q;
    awaddr_d = aw_hs ? awaddr : awaddr_q;
    wdata_d = w_hs ? wdata : wdata_q;
    wstrb_d = w_hs ? wstrb : wstrb_q;
    bresp_d = bresp_q;
    case (wr_q)
      WR_IDLE: wr_d = aw_hs && w_hs ? WR_RESP : aw_hs ? WR_ADDR : w_hs ? WR_DATA : WR_IDLE;
      WR_ADDR: wr_d = w_hs ? WR_RESP : WR_ADDR;
      WR_DATA: wr_d = aw_hs ? WR_RESP : WR_DATA;
      default: wr_d = bready ? WR_IDLE : WR_RESP;
    endcase
    wr_en = wr_d == WR_RESP && wr_q != WR_RESP;
    if (wr_en) bresp_d = addr_ok(awaddr_d) ? RESP_OKAY : RESP_SLVERR;
  end
  // read FSM: capture the response at the AR handshake and hold it until accepted
  always_comb begin
    rd_d = rd_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (ar_hs) begin
      rd_d = RD_VALID;
      rdata_d = addr_ok(araddr) ? rf_rdata : 32'h0;
      rresp_d = addr_ok(araddr) ? RESP_OKAY : RESP_SLVERR;
    end else if (rd_q == RD_VALID && rready) rd_d = RD_IDLE;
  end
  // channel state and held payloads, all cleared asynchronously
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_q <= WR_IDLE;
      rd_q <= RD_IDLE;
      awaddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bresp_q <= '0;
      rdata_q <= '0;
      rresp_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      awaddr_q <= awaddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      bresp_q <= bresp_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end
  axi4_lite_regfile #(.N(NUM_REGS), .RESET_VALUE(RESET_VALUE)) u_regfile (
    .clk_i  (aclk),
    .rst_ni (aresetn),
    .we_i   (wr_en && addr_ok(awaddr_d)),
    .widx_i (awaddr_d[5:2]),
    .wdata_i(wdata_d),
    .wstrb_i(wstrb_d),
    .ridx_i (araddr[5:2]),
    .rdata_o(rf_rdata)
  );
endmodule

// File: tb/tb_axi4_lite_slave.sv
// tb_axi4_lite_slave: directed scoreboard bench for the AXI4-Lite register slave
module tb_axi4_lite_slave;
  logic aclk = 0, aresetn = 0;
  logic [31:0] araddr = 0, awaddr = 0, wdata = 0, rdata;
  logic arvalid = 0, rready = 0, awvalid = 0, wvalid = 0, bready = 0;
  logic [3:0] wstrb = 0;
  logic arready, rvalid, awready, wready, bvalid;
  logic [1:0] rresp, bresp;
  int checks = 0, errors = 0;
  logic [1:0] b_exp[$];
  logic [33:0] r_exp[$];

  axi4_lite_slave dut (
    .aclk(aclk), .aresetn(aresetn),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  // monitor: compare every accepted B and R beat against the scoreboard
  always @(negedge aclk) begin
    if (aresetn && bvalid && bready) begin
      if (b_exp.size() == 0) check("b_unexpected", 1, 0);
      else check("bresp", {30'h0, bresp}, {30'h0, b_exp.pop_front()});
    end
    if (aresetn && rvalid && rready) begin
      if (r_exp.size() == 0) check("r_unexpected", 1, 0);
      else begin
        logic [33:0] e;
        e = r_exp.pop_front();
        check("rdata", rdata, e[31:0]);
        check("rresp", {30'h0, rresp}, {30'h0, e[33:32]});
      end
    end
  end

  task automatic issue_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit ad = 0, wd = 0;
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    while (!(ad && wd) && n < 20) begin
      @(negedge aclk);
      if (awvalid && awready) ad = 1;
      if (wvalid && wready) wd = 1;
      @(posedge aclk); #1;
      if (ad) awvalid = 0;
      if (wd) wvalid = 0;
      n++;
    end
    if (!(ad && wd)) timeout("aw_w_handshake");
  endtask

  task automatic wait_b();
    int n = 0;
    do begin @(negedge aclk); n++; end while (!(bvalid && bready) && n < 20);
    if (!(bvalid && bready)) timeout("b_handshake");
    @(posedge aclk); #1;
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] r);
    b_exp.push_back(r);
    bready = 1;
    issue_write(a, d, s);
    wait_b();
  endtask

  task automatic issue_read(input logic [31:0] a);
    int n = 0;
    araddr = a; arvalid = 1;
    do begin @(negedge aclk); n++; end while (!arready && n < 20);
    if (!arready) timeout("ar_handshake");
    @(posedge aclk); #1;
    arvalid = 0;
  endtask

  task automatic wait_r();
    int n = 0;
    do begin @(negedge aclk); n++; end while (!(rvalid && rready) && n < 20);
    if (!(rvalid && rready)) timeout("r_handshake");
    @(posedge aclk); #1;
  endtask

  task automatic read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    r_exp.push_back({r, d});
    rready = 1;
    issue_read(a);
    wait_r();
  endtask

  initial begin
    #3;
    check("rst_awready", {31'h0, awready}, 0);
    check("rst_wready", {31'h0, wready}, 0);
    check("rst_arready", {31'h0, arready}, 0);
    check("rst_bvalid", {31'h0, bvalid}, 0);
    check("rst_rvalid", {31'h0, rvalid}, 0);
    check("rst_rdata", rdata, 0);
    #20 aresetn = 1;
    @(posedge aclk); #1;
    check("post_rst_awready", {31'h0, awready}, 1);
    // basic writes and readback
    write(32'h00, 32'hA5A5A5A5, 4'hF, 2'b00);
    write(32'h04, 32'hF0F00F0F, 4'hF, 2'b00);
    read(32'h00, 32'hA5A5A5A5, 2'b00);
    read(32'h04, 32'hF0F00F0F, 2'b00);
    // partial strobe merge
    write(32'h08, 32'h12345678, 4'hF, 2'b00);
    write(32'h08, 32'hDEADBEEF, 4'b0011, 2'b00);
    read(32'h08, 32'h1234BEEF, 2'b00);
    // out-of-range access refused, aliased register untouched
    write(32'h1000, 32'hDEADBEEF, 4'hF, 2'b10);
    read(32'h1000, 32'h0, 2'b10);
    read(32'h00, 32'hA5A5A5A5, 2'b00);
    read(32'h0B, 32'h1234BEEF, 2'b00);
    // AW three cycles ahead of W
    bready = 1;
    awaddr = 32'h0C; awvalid = 1;
    @(negedge aclk);
    check("aw_first_awready", {31'h0, awready}, 1);
    @(posedge aclk); #1;
    awvalid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("aw_held_awready", {31'h0, awready}, 0);
      check("aw_held_wready", {31'h0, wready}, 1);
      check("aw_held_bvalid", {31'h0, bvalid}, 0);
      @(posedge aclk); #1;
    end
    b_exp.push_back(2'b00);
    wdata = 32'h55AA55AA; wstrb = 4'hF; wvalid = 1;
    @(negedge aclk);
    check("w_late_bvalid_before", {31'h0, bvalid}, 0);
    @(posedge aclk); #1;
    wvalid = 0;
    @(negedge aclk);
    check("w_late_bvalid_after", {31'h0, bvalid}, 1);
    @(posedge aclk); #1;
    @(negedge aclk);
    check("w_late_bvalid_cleared", {31'h0, bvalid}, 0);
    check("w_late_awready_back", {31'h0, awready}, 1);
    @(posedge aclk); #1;
    read(32'h0C, 32'h55AA55AA, 2'b00);
    // B backpressure with an error response
    bready = 0;
    b_exp.push_back(2'b10);
    issue_write(32'h40, 32'h11112222, 4'hF);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("bstall_bvalid", {31'h0, bvalid}, 1);
      check("bstall_bresp", {30'h0, bresp}, 2'b10);
      check("bstall_awready", {31'h0, awready}, 0);
      check("bstall_wready", {31'h0, wready}, 0);
      @(posedge aclk); #1;
    end
    bready = 1;
    wait_b();
    // R backpressure
    rready = 0;
    r_exp.push_back({2'b00, 32'hF0F00F0F});
    issue_read(32'h04);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("rstall_rvalid", {31'h0, rvalid}, 1);
      check("rstall_rdata", rdata, 32'hF0F00F0F);
      check("rstall_arready", {31'h0, arready}, 0);
      @(posedge aclk); #1;
    end
    rready = 1;
    wait_r();
    // reset while a write response is pending
    bready = 0;
    issue_write(32'h00, 32'h99999999, 4'hF);
    @(negedge aclk);
    check("pre_rst_bvalid", {31'h0, bvalid}, 1);
    #2 aresetn = 0;
    #1;
    check("mid_rst_bvalid", {31'h0, bvalid}, 0);
    check("mid_rst_awready", {31'h0, awready}, 0);
    bready = 1;
    #21 aresetn = 1;
    @(posedge aclk); #1;
    read(32'h00, 32'h0, 2'b00);
    read(32'h08, 32'h0, 2'b00);
    repeat (3) @(posedge aclk);
    check("b_queue_drained", b_exp.size(), 0);
    check("r_queue_drained", r_exp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi4_lite_slave.md
Name: axi4_lite_slave

Overview:
- AXI4-Lite slave exposing a bank of 16 32-bit read/write registers to a bus master.
- Write channels (AW, W, B) and read channels (AR, R) are handled by independent FSMs.
- Sits at a peripheral's bus boundary; register contents feed local control logic.
- Out-of-range accesses are refused with SLVERR.

Parameters:
- NUM_REGS, 16, number of 32-bit registers; word-aligned at byte offsets 0x00..0x3C.
- RESET_VALUE, 32'h0000_0000, reset content of every register.

Ports:
- aclk  input  1  system clock; all logic is rising-edge.
- aresetn  input  1  asynchronous active-low reset.
- araddr  input  32  read address.
- arvalid  input  1  read address valid.
- arready  output  1  read address ready.
- rdata  output  32  read data.
- rresp  output  2  read response.
- rvalid  output  1  read data valid.
- rready  input  1  master ready for read data.
- awaddr  input  32  write address.
- awvalid  input  1  write address valid.
- awready  output  1  write address ready.
- wdata  input  32  write data.
- wstrb  input  4  byte-lane strobes; bit i enables wdata[8i+7:8i].
- wvalid  input  1  write data valid.
- wready  output  1  write data ready.
- bresp  output  2  write response.
- bvalid  output  1  write response valid.
- bready  input  1  master ready for write response.

Behaviour:
- Reset (aresetn low, asynchronous):
  - All registers take RESET_VALUE.
  - bvalid, rvalid, rdata, rresp and bresp go to 0.
  - Any held address or data is discarded.
  - awready, wready and arready are 0 while aresetn is low.
- Address decode:
  - awaddr/araddr bits [1:0] are ignored.
  - The access is valid iff bits [31:6] are 0; register index is bits [5:2].
  - Response codes: OKAY = 2'b00, SLVERR = 2'b10.
- Write path:
  - awready is high when no write address is held and bvalid is low.
  - wready is high when no write data is held and bvalid is low.
  - AW and W may complete in the same cycle or in either order.
  - Each channel's payload is latched at its own handshake.
  - Once both are held (or both handshake at edge N), the selected register is updated at that edge, only for lanes with wstrb set.
  - bvalid rises in the next cycle with bresp = OKAY, or SLVERR for an invalid address (no register changes).
  - bvalid and bresp stay stable until bready is high at a rising edge; bvalid then clears and both readies return high in the following cycle.
  - Write latency with bready held high: handshake at edge N → bvalid visible N..N+1 → cleared at edge N+1.
- Read path:
  - arready is high when rvalid is low.
  - On AR handshake at edge N, rdata, rresp and rvalid are registered at edge N, so they are visible in the next cycle.
  - rdata = register value for a valid address; 0 with SLVERR for an invalid address.
  - rvalid, rdata and rresp hold until rready is high at an edge; arready returns after rvalid clears.
  - One outstanding read at most.
- Simultaneous read and write to the same register in one cycle: the read returns the pre-write value.
- Read and write paths never block each other.
- Reset asserted mid-transaction aborts it immediately; no response is issued afterwards.
- Channel inputs are not checked for stability; the master is responsible for AXI compliance.

Decomposition:
- Package axi4_lite_pkg:
  - RESP_OKAY and RESP_SLVERR constants.
  - NUM_REGS and the address-valid decode constant (upper-bits mask).
  - Register-index typedef.
- One sub-module, axi4_lite_regfile:
  - Register array with byte-strobed write port and combinational read port.
  - The slave wraps it with the channel FSMs.

Test Plan:
- Write 0x00 ← 0xA5A5A5A5 (wstrb 4'hF), then write 0x04 ← 0xF0F00F0F → both give bresp 00. Read 0x00 → rdata 0xA5A5A5A5, rresp 00; read 0x04 → 0xF0F00F0F.
- Write 0x08 ← 0x12345678, then write 0x08 ← 0xDEADBEEF with wstrb 4'b0011 → read 0x08 returns 0x1234BEEF.
- Write 0x1000 ← 0xDEADBEEF → bresp 10 and no register changes. Read 0x1000 → rdata 0, rresp 10.
- AW presented 3 cycles before W → awready drops after the AW handshake, wready stays high. Write completes at the W handshake; bvalid follows one cycle later.
- Hold bready low for 5 cycles → bvalid and bresp stay stable, awready/wready stay low. Hold rready low → rvalid and rdata stay stable, arready stays low.
- Assert aresetn low while bvalid is high → bvalid is 0 immediately. After release, read 0x00 → 0x00000000.
